number_display: RTL and testbench

NUMBER_DISPLAY -- requirements
Module: number_display

---
 rtl/number_display.sv | 232 +++++++++++++++++++++++
 tb/tb_number_display.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/number_display.sv
// number_display: selects one of two 14-bit operands, converts it to four BCD
// digits with a serial double-dabble FSM, and time-multiplexes the digits onto
// an active-low 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zeros in
// digit positions 3..1; the ones digit is always shown).
module number_display #(
  parameter int SCAN_DIVIDER = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] number_1,
  input  logic [13:0] number_2,
  input  logic        write_number_select,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = (SCAN_DIVIDER > 2) ? $clog2(SCAN_DIVIDER) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIVIDER - 1);
  localparam logic [13:0] MAX_DISPLAY = 14'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [13:0]   sel_val;
  logic [13:0]   last_val;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic [15:0]   bcd_adj;
  logic [3:0]    shift_cnt;
  logic          ovf_cap;
  logic [15:0]   digits;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    cur_nibble;
  logic          blank;
  logic [6:0]    seg_next;

  // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit; anything else is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  assign sel_val = write_number_select ? number_2 : number_1;
  assign bcd_adj = dabble_adjust(bcd);

  // Converter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Converter next-state logic: start on a changed operand, shift 14 times, commit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sel_val != last_val) begin
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD:  next_state = SHIFT;
      SHIFT: begin
        if (shift_cnt == 4'd13) begin
          next_state = DONE;
        end else begin
          next_state = SHIFT;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Conversion datapath: operand capture and one double-dabble step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin       <= 14'd0;
      bcd       <= 16'd0;
      shift_cnt <= 4'd0;
      last_val  <= 14'd0;
      ovf_cap   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bin       <= (sel_val > MAX_DISPLAY) ? MAX_DISPLAY : sel_val;
          bcd       <= 16'd0;
          shift_cnt <= 4'd0;
          last_val  <= sel_val;
          ovf_cap   <= (sel_val > MAX_DISPLAY);
        end
        SHIFT: begin
          bcd       <= {bcd_adj[14:0], bin[13]};
          bin       <= {bin[12:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
        end
        default: begin
          bin <= bin;
        end
      endcase
    end
  end

  // Display digit registers and overflow flag change only when a conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits   <= 16'd0;
      overflow <= 1'b0;
    end else if (state == DONE) begin
      digits   <= bcd;
      overflow <= ovf_cap;
    end else begin
      digits   <= digits;
      overflow <= overflow;
    end
  end

  // busy is registered from the next state so it tracks LOAD/SHIFT/DONE exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
    end
  end

  // Scan timer: each digit stays enabled for SCAN_DIVIDER cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + CW'(1);
      digit_idx <= digit_idx;
    end
  end

  // Pick the nibble for the digit currently being scanned.
  always_comb begin
    cur_nibble = 4'd0;
    case (digit_idx)
      2'd0:    cur_nibble = digits[3:0];
      2'd1:    cur_nibble = digits[7:4];
      2'd2:    cur_nibble = digits[11:8];
      2'd3:    cur_nibble = digits[15:12];
      default: cur_nibble = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every more-significant digit are zero (never the ones digit).
  always_comb begin
    blank = 1'b0;
    case (digit_idx)
      2'd1:    blank = (digits[15:4] == 12'd0);
      2'd2:    blank = (digits[15:8] == 8'd0);
      2'd3:    blank = (digits[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  // Every digit is always shown, including leading zeros.
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Segment pattern for the current digit before output registration.
  always_comb begin
    seg_next = 7'b1111111;
    if (blank) begin
      seg_next = 7'b1111111;
    end else begin
      seg_next = seg_decode(cur_nibble);
    end
  end

  // Registered display drive: one-hot active-low anode plus its segment pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_number_display.sv
// Self-checking bench for number_display: directed latency/abort sequences,
// a table of operand vectors, and random operands against a decimal model.
module tb_number_display;

  localparam int DIV = 3;

  logic        clk;
  logic        rst_n;
  logic [13:0] number_1;
  logic [13:0] number_2;
  logic        write_number_select;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  logic [6:0] seg_tab [10];

  typedef struct {
    int n1;
    int n2;
    int sel;
    int exp_val;
    int exp_ovf;
  } vec_t;

  vec_t vecs [10];

  number_display #(.SCAN_DIVIDER(DIV)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .number_1            (number_1),
    .number_2            (number_2),
    .write_number_select (write_number_select),
    .seg                 (seg),
    .an                  (an),
    .busy                (busy),
    .overflow            (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected segment pattern for decimal position p of displayed value v.
  function automatic logic [6:0] exp_seg(input int v, input int p);
    int pw;
    pw = (p == 0) ? 1 : (p == 1) ? 10 : (p == 2) ? 100 : 1000;
`ifdef LEADING_ZERO_BLANK_EN
    if (p > 0 && v < pw) return 7'b1111111;
`endif
    return seg_tab[(v / pw) % 10];
  endfunction

  task automatic set_in(input int n1, input int n2, input int sel);
    @(negedge clk);
    number_1 = 14'(n1);
    number_2 = 14'(n2);
    write_number_select = sel[0];
  endtask

  // Wait for any conversion to finish (bounded), then let the outputs settle.
  task automatic settle(input string name);
    int n;
    repeat (3) @(posedge clk);
    #1;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
    repeat (2) @(posedge clk);
  endtask

  // Scan one full display frame and compare every digit and the overflow flag.
  task automatic check_display(input string name, input int v, input int ovf);
    logic [6:0] seen [4];
    bit got [4];
    int idx;
    for (int p = 0; p < 4; p++) begin
      got[p] = 1'b0;
      seen[p] = 7'h00;
    end
    for (int c = 0; c < 4 * DIV; c++) begin
      @(posedge clk);
      #1;
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        tests++;
        fails++;
        $display("FAIL %s_an_onehot: got an=%b, expected one low bit", name, an);
      end else begin
        got[idx] = 1'b1;
        seen[idx] = seg;
      end
    end
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s_digit%0d", name, p), {24'd0, got[p], seen[p]}, {24'd0, 1'b1, exp_seg(v, p)});
    end
    check($sformatf("%s_overflow", name), {31'd0, overflow}, ovf[31:0]);
  endtask

  initial begin
    int first_hi;
    int fall;
    int hi_cnt;
    int sv;
    int n1;
    int n2;
    int sl;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0] = '{0,     0,  0, 0,    0};
    vecs[1] = '{9999,  0,  0, 9999, 0};
    vecs[2] = '{10000, 0,  0, 9999, 1};
    vecs[3] = '{10000, 3,  1, 3,    0};
    vecs[4] = '{16383, 3,  1, 3,    0};
    vecs[5] = '{16383, 3,  0, 9999, 1};
    vecs[6] = '{1,     3,  0, 1,    0};
    vecs[7] = '{1000,  3,  0, 1000, 0};
    vecs[8] = '{1000,  10, 1, 10,   0};
    vecs[9] = '{90,    10, 1, 10,   0};

    rst_n = 1'b0;
    number_1 = 14'd0;
    number_2 = 14'd0;
    write_number_select = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // Idle scan with zero operand: anode rotation and digit patterns, no conversion.
    for (int k = 1; k <= 8 * DIV; k++) begin
      int ix;
      @(posedge clk);
      #1;
      ix = ((k - 1) / DIV) % 4;
      check($sformatf("idle_an_k%0d", k), {28'd0, an}, {28'd0, 4'b1111 ^ (4'b0001 << ix)});
      check($sformatf("idle_seg_k%0d", k), {25'd0, seg}, {25'd0, exp_seg(0, ix)});
      check($sformatf("idle_busy_k%0d", k), {31'd0, busy}, 32'd0);
    end

    // 1234: busy rises one cycle after the change, stays 16 cycles, digits land at 17.
    set_in(1234, 0, 0);
    first_hi = -1;
    fall = -1;
    hi_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = k;
      end else if (first_hi >= 0 && fall < 0) begin
        fall = k;
      end
    end
    check("lat_busy_rise", first_hi, 1);
    check("lat_done", fall, 17);
    check("lat_busy_len", hi_cnt, 16);
    check_display("v1234", 1234, 0);

    // Overflow via select toggle, then clear with a small value.
    set_in(1234, 12000, 1);
    settle("ovf");
    check_display("v12000", 9999, 1);
    set_in(1234, 5, 1);
    settle("small");
    check_display("v5", 5, 0);

    // Operand changes mid-conversion: 42 completes first, then 77 follows at once.
    set_in(42, 5, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    number_1 = 14'd77;
    for (int k = 7; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (k == 17) check("mid_busy_fall", {31'd0, busy}, 32'd0);
      if (k == 18) check("mid_busy_restart", {31'd0, busy}, 32'd1);
    end
    check_display("mid_v42", 42, 0);
    settle("mid");
    check_display("mid_v77", 77, 0);

    // Reset in the 8th SHIFT cycle of 9876 aborts; the value is reconverted afterwards.
    set_in(9876, 5, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_an", {28'd0, an}, 32'hF);
    check("abort_seg", {25'd0, seg}, 32'h7F);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_first_an", {28'd0, an}, 32'hE);
    check("abort_first_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    check("abort_restart_busy", {31'd0, busy}, 32'd1);
    check_display("abort_hold0", 0, 0);
    settle("abort");
    check_display("abort_v9876", 9876, 0);

    // Table of operand vectors.
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].n1, vecs[i].n2, vecs[i].sel);
      settle($sformatf("vec%0d", i));
      check_display($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_ovf);
    end

    // Random operands against the decimal model.
    for (int i = 0; i < 12; i++) begin
      n1 = int'($urandom_range(0, 16383));
      n2 = int'($urandom_range(0, 16383));
      sl = int'($urandom_range(0, 1));
      sv = (sl != 0) ? n2 : n1;
      set_in(n1, n2, sl);
      settle($sformatf("rnd%0d", i));
      check_display($sformatf("rnd%0d_val%0d", i, sv), (sv > 9999) ? 9999 : sv, (sv > 9999) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
